// File: rtl/mux_n21_pipe_pkg.sv
// Shared definitions for the N-to-1 flow-controlled select: occupancy states
// of the output stage and the select-width helper.
package mux_n21_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // Minimum select width for n inputs; never below one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_n21_pipe_skid.sv
// One-cycle valid/ready register stage with a skid entry, so a beat accepted
// while the consumer stalls is parked instead of dropped.
module skid_stage
    import mux_n21_pipe_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    occ_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         deliver;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // The parked beat is older than anything upstream, so it goes next.
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        // Handshake flags are registered copies of the next occupancy, which
        // keeps out_ready off any combinational path to in_ready.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Skid contents are never visible while empty, so they need no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: rtl/mux_n21_pipe.sv
// N-to-1 operand select with range check, feeding a registered valid/ready
// stage that carries {err, data} per beat.
module mux_n21_pipe
    import mux_n21_pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    w_clk,
    input  logic                    w_rst_n,
    input  logic [NUM_IN*WIDTH-1:0] w_in_flat_x,
    input  logic [SEL_W-1:0]        w_ctrl_s,
    input  logic                    w_in_valid,
    output logic                    w_in_ready,
    input  logic                    w_flush,
    output logic [WIDTH-1:0]        w_out_x,
    output logic                    w_out_err,
    output logic                    w_out_valid,
    input  logic                    w_out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   stage_out;

    // Any select value that matches no input yields a zero beat flagged as an error.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_ctrl_s == SEL_W'(i)) begin
                sel_data = w_in_flat_x[i*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    skid_stage #(
        .W(WIDTH + 1)
    ) u_stage (
        .clk      (w_clk),
        .rst_n    (w_rst_n),
        .in_data  ({sel_err, sel_data}),
        .in_valid (w_in_valid),
        .in_ready (w_in_ready),
        .flush    (w_flush),
        .out_data (stage_out),
        .out_valid(w_out_valid),
        .out_ready(w_out_ready)
    );

    assign w_out_err = stage_out[WIDTH];
    assign w_out_x   = stage_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_n21_pipe.sv
// Randomized bench for mux_n21_pipe (NUM_IN=5) against a queue-based model of
// the two-entry flow-controlled select.
module tb_mux_n21_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;

    logic                    w_clk;
    logic                    w_rst_n;
    logic [NUM_IN*WIDTH-1:0] w_in_flat_x;
    logic [SEL_W-1:0]        w_ctrl_s;
    logic                    w_in_valid;
    logic                    w_in_ready;
    logic                    w_flush;
    logic [WIDTH-1:0]        w_out_x;
    logic                    w_out_err;
    logic                    w_out_valid;
    logic                    w_out_ready;

    logic [WIDTH-1:0] in_arr [NUM_IN];
    logic [WIDTH:0]   exp_q [$];
    int               n_cmp;
    int               n_bad;
    int               n_delivered;

    mux_n21_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_in_flat_x(w_in_flat_x),
        .w_ctrl_s   (w_ctrl_s),
        .w_in_valid (w_in_valid),
        .w_in_ready (w_in_ready),
        .w_flush    (w_flush),
        .w_out_x    (w_out_x),
        .w_out_err  (w_out_err),
        .w_out_valid(w_out_valid),
        .w_out_ready(w_out_ready)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    always_comb begin
        w_in_flat_x = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_in_flat_x[i*WIDTH +: WIDTH] = in_arr[i];
        end
    end

    task automatic check_val(input string tag, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_IN; i++) begin
            in_arr[i] = $urandom;
        end
    endtask

    // Model state: the queue holds every beat the stage owns, oldest first.
    task automatic compare_outputs();
        logic [WIDTH:0] head;
        check_val("in_ready", {32'h0, w_in_ready}, {32'h0, exp_q.size() < 2});
        check_val("out_valid", {32'h0, w_out_valid}, {32'h0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check_val("out_x", {1'b0, w_out_x}, {1'b0, head[WIDTH-1:0]});
            check_val("out_err", {32'h0, w_out_err}, {32'h0, head[WIDTH]});
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare at the next falling edge.
    task automatic drive(input logic v, input logic [SEL_W-1:0] sel, input logic fl, input logic ordy);
        logic           acc;
        logic           dlv;
        logic [WIDTH:0] beat;
        w_in_valid  = v;
        w_ctrl_s    = sel;
        w_flush     = fl;
        w_out_ready = ordy;
        acc = v && (exp_q.size() < 2);
        dlv = ordy && (exp_q.size() > 0);
        if (int'(sel) < NUM_IN) beat = {1'b0, in_arr[sel]};
        else                    beat = {1'b1, {WIDTH{1'b0}}};
        if (dlv) begin
            void'(exp_q.pop_front());
            n_delivered++;
        end
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(beat);
        @(negedge w_clk);
        compare_outputs();
    endtask

    initial begin
        logic [WIDTH-1:0] a_val;
        logic [WIDTH-1:0] b_val;
        int               sent;
        int               budget;

        n_cmp = 0;
        n_bad = 0;
        n_delivered = 0;
        w_rst_n = 1'b0;
        w_in_valid = 1'b0;
        w_ctrl_s = '0;
        w_flush = 1'b0;
        w_out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) in_arr[i] = '0;
        @(negedge w_clk);
        @(negedge w_clk);
        check_val("rst_out_x", {1'b0, w_out_x}, '0);
        check_val("rst_out_valid", {32'h0, w_out_valid}, '0);
        check_val("rst_in_ready", {32'h0, w_in_ready}, 33'd1);
        w_rst_n = 1'b1;
        @(negedge w_clk);
        compare_outputs();

        // Basic select with one-cycle latency.
        rand_data();
        in_arr[2] = 32'hDEAD_BEEF;
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        check_val("dead_x", {1'b0, w_out_x}, {1'b0, 32'hDEAD_BEEF});
        check_val("dead_err", {32'h0, w_out_err}, '0);
        check_val("dead_valid", {32'h0, w_out_valid}, 33'd1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);

        // Out-of-range select, then the highest legal index.
        rand_data();
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        check_val("oor_x", {1'b0, w_out_x}, '0);
        check_val("oor_err", {32'h0, w_out_err}, 33'd1);
        drive(1'b1, 3'd4, 1'b0, 1'b1);
        check_val("sel4_err", {32'h0, w_out_err}, '0);
        check_val("sel4_x", {1'b0, w_out_x}, {1'b0, in_arr[4]});
        drive(1'b0, 3'd0, 1'b0, 1'b1);

        // Back-pressure: A then B parked, released in order.
        rand_data();
        a_val = in_arr[0];
        b_val = in_arr[1];
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        check_val("bp_in_ready", {32'h0, w_in_ready}, '0);
        check_val("bp_hold_a", {1'b0, w_out_x}, {1'b0, a_val});
        rand_data();
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        check_val("bp_still_a", {1'b0, w_out_x}, {1'b0, a_val});
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        check_val("bp_then_b", {1'b0, w_out_x}, {1'b0, b_val});
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        check_val("bp_empty", {32'h0, w_out_valid}, '0);

        // Stream of 100 beats under random back-pressure.
        n_delivered = 0;
        sent = 0;
        budget = 2000;
        while ((n_delivered < 100 || exp_q.size() > 0) && budget > 0) begin
            logic v;
            v = (sent < 100);
            if (v && exp_q.size() < 2) sent++;
            rand_data();
            drive(v, 3'($urandom_range(0, NUM_IN - 1)), 1'b0, 1'($urandom_range(0, 1)));
            budget--;
        end
        check_val("stream_delivered", 33'(n_delivered), 33'd100);

        // Flush while full with a beat offered.
        rand_data();
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 1'b1, 1'b0);
        check_val("flush_valid", {32'h0, w_out_valid}, '0);
        check_val("flush_in_ready", {32'h0, w_in_ready}, 33'd1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        check_val("flush_no_ghost", {32'h0, w_out_valid}, '0);

        // Random mix including flushes and out-of-range selects.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset between clock edges.
        rand_data();
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        @(posedge w_clk);
        #2;
        w_rst_n = 1'b0;
        #1;
        check_val("arst_valid", {32'h0, w_out_valid}, '0);
        check_val("arst_x", {1'b0, w_out_x}, '0);
        check_val("arst_err", {32'h0, w_out_err}, '0);
        check_val("arst_in_ready", {32'h0, w_in_ready}, 33'd1);
        exp_q.delete();
        w_in_valid = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;
        compare_outputs();
        rand_data();
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
